// File: rtl/ps2_scancode_decoder.sv
// Set-2 scancode decoder: folds E0/F0 prefixes and the Pause sequence into single key
// events, filters typematic repeats and keeps a per-key held table.
module ps2_scancode_decoder #(
    parameter int unsigned TIMEOUT_CYCLES = 500_000,
    parameter bit          FILTER_REPEAT  = 1'b1
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [15:0] keycode_i,
    input  logic        oflag_i,
    output logic        key_valid_o,
    output logic [7:0]  key_code_o,
    output logic        key_ext_o,
    output logic        key_release_o,
    output logic        seq_err_o,
    input  logic [7:0]  query_code_i,
    input  logic        query_ext_i,
    output logic        query_held_o,
    output logic [8:0]  held_count_o
);

    localparam int unsigned TmoW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT_CYCLES - 2);

    typedef enum logic [2:0] {StIdle, StExt, StBrk, StExtBrk, StPause} state_e;

    state_e          state_q, state_d;
    logic [2:0]      pause_cnt_q, pause_cnt_d;
    logic [TmoW-1:0] tmo_q, tmo_d;
    logic [511:0]    held_q, held_d;
    logic [8:0]      count_q, count_d;
    logic            valid_q, valid_d;
    logic            seq_err_q, seq_err_d;
    logic [7:0]      code_q, code_d;
    logic            ext_q, ext_d;
    logic            rel_q, rel_d;

    logic [7:0] b;
    logic       is_status, is_prefix;
    logic       ev, ev_ext, ev_rel, pause_ev;
    logic [8:0] idx;
    logic       unused_prev;

    assign b           = keycode_i[7:0];
    assign unused_prev = ^keycode_i[15:8];
    assign is_status   = b inside {8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFE, 8'hFF};
    assign is_prefix   = b inside {8'hE0, 8'hE1, 8'hF0};

    always_comb begin
        state_d     = state_q;
        pause_cnt_d = pause_cnt_q;
        tmo_d       = tmo_q;
        held_d      = held_q;
        count_d     = count_q;
        valid_d     = 1'b0;
        seq_err_d   = 1'b0;
        code_d      = code_q;
        ext_d       = ext_q;
        rel_d       = rel_q;
        ev          = 1'b0;
        ev_ext      = 1'b0;
        ev_rel      = 1'b0;
        pause_ev    = 1'b0;

        if (oflag_i) begin
            // A byte always wins over a timeout firing in the same cycle.
            tmo_d = '0;
            if (is_status) begin
                if (state_q != StIdle) begin
                    state_d   = StIdle;
                    seq_err_d = 1'b1;
                end
            end else begin
                unique case (state_q)
                    StIdle: begin
                        if (b == 8'hE0) begin
                            state_d = StExt;
                        end else if (b == 8'hF0) begin
                            state_d = StBrk;
                        end else if (b == 8'hE1) begin
                            state_d     = StPause;
                            pause_cnt_d = 3'd7;
                        end else begin
                            ev = 1'b1;
                        end
                    end
                    StExt: begin
                        if (b == 8'hF0) begin
                            state_d = StExtBrk;
                        end else if (is_prefix) begin
                            state_d   = StIdle;
                            seq_err_d = 1'b1;
                        end else begin
                            state_d = StIdle;
                            ev      = 1'b1;
                            ev_ext  = 1'b1;
                        end
                    end
                    StBrk, StExtBrk: begin
                        state_d = StIdle;
                        if (is_prefix) begin
                            seq_err_d = 1'b1;
                        end else begin
                            ev     = 1'b1;
                            ev_rel = 1'b1;
                            ev_ext = (state_q == StExtBrk);
                        end
                    end
                    StPause: begin
                        if (pause_cnt_q == 3'd1) begin
                            state_d  = StIdle;
                            pause_ev = 1'b1;
                        end
                        pause_cnt_d = pause_cnt_q - 3'd1;
                    end
                    default: state_d = StIdle;
                endcase
            end
        end else if (state_q != StIdle) begin
            if (tmo_q == TmoLast) begin
                state_d   = StIdle;
                seq_err_d = 1'b1;
                tmo_d     = '0;
            end else begin
                tmo_d = tmo_q + TmoW'(1);
            end
        end

        idx = {ev_ext, b};
        if (ev) begin
            if (!ev_rel) begin
                if (!held_q[idx]) begin
                    held_d[idx] = 1'b1;
                    count_d     = count_q + 9'd1;
                    valid_d     = 1'b1;
                end else if (!FILTER_REPEAT) begin
                    valid_d = 1'b1;
                end
            end else begin
                // Breaks of unheld keys still emit but never touch the count.
                if (held_q[idx]) begin
                    held_d[idx] = 1'b0;
                    count_d     = count_q - 9'd1;
                end
                valid_d = 1'b1;
            end
            if (valid_d) begin
                code_d = b;
                ext_d  = ev_ext;
                rel_d  = ev_rel;
            end
        end

        if (pause_ev) begin
            valid_d = 1'b1;
            code_d  = 8'hE1;
            ext_d   = 1'b0;
            rel_d   = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= StIdle;
            pause_cnt_q <= '0;
            tmo_q       <= '0;
            held_q      <= '0;
            count_q     <= '0;
            valid_q     <= 1'b0;
            seq_err_q   <= 1'b0;
            code_q      <= '0;
            ext_q       <= 1'b0;
            rel_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            pause_cnt_q <= pause_cnt_d;
            tmo_q       <= tmo_d;
            held_q      <= held_d;
            count_q     <= count_d;
            valid_q     <= valid_d;
            seq_err_q   <= seq_err_d;
            code_q      <= code_d;
            ext_q       <= ext_d;
            rel_q       <= rel_d;
        end
    end

    assign key_valid_o   = valid_q;
    assign key_code_o    = code_q;
    assign key_ext_o     = ext_q;
    assign key_release_o = rel_q;
    assign seq_err_o     = seq_err_q;
    assign held_count_o  = count_q;
    assign query_held_o  = held_q[{query_ext_i, query_code_i}];

endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// Directed bench for ps2_scancode_decoder: a byte table drives a filtering and a
// non-filtering instance side by side, then hand-written timeout and reset sequences.
module tb_ps2_scancode_decoder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] keycode = '0;
    logic        oflag = 1'b0;
    logic [7:0]  query_code = 8'h75;
    logic        query_ext = 1'b1;

    logic       kv, ke, kr, se, qh;
    logic [7:0] kc;
    logic [8:0] hc;
    logic       kv_n, ke_n, kr_n, se_n, qh_n;
    logic [7:0] kc_n;
    logic [8:0] hc_n;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    ps2_scancode_decoder #(.TIMEOUT_CYCLES(16), .FILTER_REPEAT(1'b1)) dut (
        .clk_i(clk), .rst_ni(rst_n), .keycode_i(keycode), .oflag_i(oflag),
        .key_valid_o(kv), .key_code_o(kc), .key_ext_o(ke), .key_release_o(kr),
        .seq_err_o(se), .query_code_i(query_code), .query_ext_i(query_ext),
        .query_held_o(qh), .held_count_o(hc)
    );

    ps2_scancode_decoder #(.TIMEOUT_CYCLES(16), .FILTER_REPEAT(1'b0)) dut_nf (
        .clk_i(clk), .rst_ni(rst_n), .keycode_i(keycode), .oflag_i(oflag),
        .key_valid_o(kv_n), .key_code_o(kc_n), .key_ext_o(ke_n), .key_release_o(kr_n),
        .seq_err_o(se_n), .query_code_i(query_code), .query_ext_i(query_ext),
        .query_held_o(qh_n), .held_count_o(hc_n)
    );

    typedef struct packed {
        logic [7:0] b;
        logic       v;
        logic       e;
        logic       r;
        logic [7:0] code;
        logic [8:0] hc;
        logic       q;
        logic       se;
        logic       v_nf;
        logic [8:0] hc_nf;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input int row, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s (step %0d): got %h, expected %h", name, row, act, exp);
        end
    endtask

    task automatic add(input logic [7:0] b, input logic v, input logic e, input logic r,
                       input logic [7:0] code, input int h, input logic q, input logic s,
                       input logic vn, input int hn);
        vecs.push_back('{b, v, e, r, code, 9'(h), q, s, vn, 9'(hn)});
    endtask

    // One-cycle strobe; returns at the negedge where the resulting outputs are visible.
    task automatic send(input logic [7:0] b);
        keycode = {8'hA5, b};
        oflag   = 1'b1;
        @(negedge clk);
        oflag   = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int first;
        int pulses;

        //   b      v  e  r  code   hc q  se vnf hcnf
        add(8'h1C, 1, 0, 0, 8'h1C, 1, 0, 0, 1, 1);
        add(8'hF0, 0, 0, 0, 8'h1C, 1, 0, 0, 0, 1);
        add(8'h1C, 1, 0, 1, 8'h1C, 0, 0, 0, 1, 0);
        add(8'hE0, 0, 0, 1, 8'h1C, 0, 0, 0, 0, 0);
        add(8'h75, 1, 1, 0, 8'h75, 1, 1, 0, 1, 1);
        add(8'hE0, 0, 1, 0, 8'h75, 1, 1, 0, 0, 1);
        add(8'hF0, 0, 1, 0, 8'h75, 1, 1, 0, 0, 1);
        add(8'h75, 1, 1, 1, 8'h75, 0, 0, 0, 1, 0);
        add(8'h29, 1, 0, 0, 8'h29, 1, 0, 0, 1, 1);
        add(8'h29, 0, 0, 0, 8'h29, 1, 0, 0, 1, 1);
        add(8'h29, 0, 0, 0, 8'h29, 1, 0, 0, 1, 1);
        add(8'hF0, 0, 0, 0, 8'h29, 1, 0, 0, 0, 1);
        add(8'h29, 1, 0, 1, 8'h29, 0, 0, 0, 1, 0);
        add(8'hE1, 0, 0, 1, 8'h29, 0, 0, 0, 0, 0);
        add(8'h14, 0, 0, 1, 8'h29, 0, 0, 0, 0, 0);
        add(8'h77, 0, 0, 1, 8'h29, 0, 0, 0, 0, 0);
        add(8'hE1, 0, 0, 1, 8'h29, 0, 0, 0, 0, 0);
        add(8'hF0, 0, 0, 1, 8'h29, 0, 0, 0, 0, 0);
        add(8'h14, 0, 0, 1, 8'h29, 0, 0, 0, 0, 0);
        add(8'hF0, 0, 0, 1, 8'h29, 0, 0, 0, 0, 0);
        add(8'h77, 1, 0, 0, 8'hE1, 0, 0, 0, 1, 0);
        add(8'hAA, 0, 0, 0, 8'hE1, 0, 0, 0, 0, 0);
        add(8'hFA, 0, 0, 0, 8'hE1, 0, 0, 0, 0, 0);
        add(8'hF0, 0, 0, 0, 8'hE1, 0, 0, 0, 0, 0);
        add(8'hFA, 0, 0, 0, 8'hE1, 0, 0, 1, 0, 0);
        add(8'h1C, 1, 0, 0, 8'h1C, 1, 0, 0, 1, 1);
        add(8'hF0, 0, 0, 0, 8'h1C, 1, 0, 0, 0, 1);
        add(8'h1C, 1, 0, 1, 8'h1C, 0, 0, 0, 1, 0);
        add(8'hF0, 0, 0, 1, 8'h1C, 0, 0, 0, 0, 0);
        add(8'h33, 1, 0, 1, 8'h33, 0, 0, 0, 1, 0);

        // Reset state
        repeat (3) @(negedge clk);
        chk("reset key_valid", 0, 32'(kv), 32'd0);
        chk("reset fields", 0, 32'({ke, kr, kc}), 32'd0);
        chk("reset seq_err", 0, 32'(se), 32'd0);
        chk("reset held_count", 0, 32'(hc), 32'd0);
        chk("reset query_held", 0, 32'(qh), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        foreach (vecs[i]) begin
            send(vecs[i].b);
            chk("key_valid", i, 32'(kv), 32'(vecs[i].v));
            chk("event fields", i, 32'({ke, kr, kc}),
                32'({vecs[i].e, vecs[i].r, vecs[i].code}));
            chk("held_count", i, 32'(hc), 32'(vecs[i].hc));
            chk("query_held 1/75", i, 32'(qh), 32'(vecs[i].q));
            chk("seq_err", i, 32'(se), 32'(vecs[i].se));
            chk("nf key_valid", i, 32'(kv_n), 32'(vecs[i].v_nf));
            chk("nf held_count", i, 32'(hc_n), 32'(vecs[i].hc_nf));
            chk("nf seq_err", i, 32'(se_n), 32'(vecs[i].se));
        end

        // Timeout: E0 at cycle N, seq_err expected at N+16 (loop index 15).
        send(8'hE0);
        first  = -1;
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            if (se && first < 0) first = i;
            if (se) pulses++;
            if (kv) pulses += 100;
            @(negedge clk);
        end
        chk("timeout pulse cycle", 100, 32'(first), 32'd15);
        chk("timeout pulse count", 100, 32'(pulses), 32'd1);
        query_code = 8'h1C;
        query_ext  = 1'b0;
        send(8'h1C);
        chk("post-timeout event", 101, 32'({kv, ke, kr, kc}), 32'({1'b1, 1'b0, 1'b0, 8'h1C}));
        chk("post-timeout held", 101, 32'({qh, hc}), 32'({1'b1, 9'd1}));

        // Reset mid-sequence clears the table and the pending prefix.
        send(8'hE0);
        rst_n = 1'b0;
        #1;
        chk("async reset held", 102, 32'({qh, hc}), 32'd0);
        chk("async reset valid", 102, 32'({kv, se}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send(8'h75);
        chk("post-reset event", 103, 32'({kv, ke, kr, kc}), 32'({1'b1, 1'b0, 1'b0, 8'h75}));
        chk("post-reset held_count", 103, 32'(hc), 32'd1);
        @(negedge clk);
        chk("strobe width", 104, 32'(kv), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/ps2_scancode_decoder.md
# ps2_scancode_decoder

Consumes the raw byte stream from the PS/2 receiver (`keycode[15:0]` plus its one-cycle `oflag` strobe) and turns Set-2 scancode sequences into single key events. Each event carries `{extended, released, code}`. The block strips `E0`/`F0` prefixes, collapses the 8-byte Pause sequence and optionally filters typematic repeats. It also keeps a per-key held table that downstream game/UI logic can query. It sits between the PS/2 receiver and all keyboard consumers, in the same clock domain.

## Interface
- `TIMEOUT_CYCLES`, default 500_000: idle clocks allowed inside a multi-byte sequence (5 ms at 100 MHz) before abort.
- `FILTER_REPEAT`, default 1: when 1, a make of an already-held key produces no event.
- `clk`  in  1  system clock; all logic on posedge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `keycode`  in  16  receiver output `{prev, cur}`; only `keycode[7:0]` is used.
- `oflag`  in  1  one-cycle strobe: `keycode[7:0]` holds a new byte this cycle.
- `key_valid`  out  1  one-cycle event strobe.
- `key_code`  out  8  base scancode of the event (`0xE1` for Pause).
- `key_ext`  out  1  event was `E0`-prefixed.
- `key_release`  out  1  event is a break.
- `seq_err`  out  1  one-cycle pulse on timeout or malformed sequence.
- `query_code`  in  8  held-table lookup code.
- `query_ext`  in  1  held-table lookup extended bit.
- `query_held`  out  1  combinational read of the held bit at `{query_ext, query_code}`.
- `held_count`  out  9  number of keys currently held (0..256 practical).

## Operation
- A byte `b` is consumed on every posedge where `oflag`=1. Back-to-back strobes are each a separate byte.
- Status bytes `00, AA, EE, FA, FC, FE, FF`:
  - In IDLE: ignored, no event, no `seq_err`.
  - In any other state: abort to IDLE and pulse `seq_err`.
- FSM states: IDLE, EXT, BRK, EXT_BRK, PAUSE.
- From IDLE:
  - `E0` → EXT.
  - `F0` → BRK.
  - `E1` → PAUSE, with the skip counter set to 7.
  - Any other byte: make event `{0,0,b}` → IDLE.
- From EXT:
  - `F0` → EXT_BRK.
  - `E0`/`E1`: `seq_err`, → IDLE.
  - Any other byte: make event `{1,0,b}` → IDLE.
- From BRK:
  - `E0`/`E1`/`F0`: `seq_err`, → IDLE.
  - Any other byte: break event `{0,1,b}` → IDLE.
- From EXT_BRK:
  - Prefix bytes: `seq_err`, → IDLE.
  - Any other byte: break event `{1,1,b}` → IDLE.
- PAUSE:
  - Each byte decrements the counter; contents are not checked.
  - When the counter reaches 0, emit `{0,0,E1}` → IDLE.
  - Pause is never entered in the held table.
- Timeout:
  - In any non-IDLE state, a counter runs and clears on each consumed byte.
  - When it reaches `TIMEOUT_CYCLES`-1 with no byte: → IDLE, pulse `seq_err`, no event.
- Held table: 512 bits indexed `{ext, code}`.
  - Make with bit=0: set the bit, increment `held_count`, emit the event.
  - Make with bit=1: emit only if `FILTER_REPEAT`=0; bit and count unchanged.
  - Break with bit=1: clear the bit, decrement `held_count`, emit.
  - Break with bit=0: emit; bit and count unchanged (count never underflows).
- `key_code`, `key_ext` and `key_release` hold their last event values between strobes.

## Timing
- Reset (async assert, sync release): `key_valid`=0, `key_code`=0, `key_ext`=0, `key_release`=0, `seq_err`=0, `held_count`=0, FSM=IDLE, held table cleared, timeout counter=0.
- Latency: the `oflag` cycle carrying the final byte is cycle N. `key_valid` and the event fields are registered and appear at cycle N+1.
- The held table and `held_count` update at the same N+1 edge.
- `query_held` reflects the table state of the current cycle; a lookup issued at N+1 sees the update.
- `key_valid` and `seq_err` never assert in the same cycle.
- Timeout: a byte arriving in the exact cycle the timeout fires is consumed, and the timeout is discarded (byte wins).
- `rst_n` asserted mid-sequence: immediate return to IDLE, no event, table cleared.
- Maximum event rate is one per consumed byte; no backpressure, so consumers must accept every strobe.

## Test plan
- Bytes `1C` then `F0 1C` (A press/release): `key_valid` twice, with `{ext,rel,code}`={0,0,1C} then {0,1,1C}. `held_count` goes 0→1→0.
- Bytes `E0 75`, `E0 F0 75` (Up arrow): events {1,0,75} then {1,1,75}. `query_held` for ext=1, code=75 reads 1 between the events, 0 after.
- `FILTER_REPEAT`=1, bytes `29 29 29 F0 29`: exactly 2 events, {0,0,29} and {0,1,29}. With `FILTER_REPEAT`=0: 4 events, `held_count` peaks at 1.
- Bytes `E1 14 77 E1 F0 14 F0 77`: single event {0,0,E1} one cycle after the 8th strobe; `held_count` stays 0.
- `TIMEOUT_CYCLES`=16, byte `E0` then 20 idle cycles: `seq_err` pulses 16 cycles after the `E0` strobe. A following `1C` yields {0,0,1C}, not extended.
- Bytes `AA`, `FA` in IDLE: no events. Byte `F0` followed by `FA`: `seq_err`=1, no event, FSM back in IDLE. `rst_n` pulsed after `E0`: the next `75` yields {0,0,75}.
